alu_seq_ctrl: RTL

- Parametrised successor to the fixed 6-bit ALU/FSM controller: a WIDTH-bit ALU sequenced by an FSM with a start/busy/done handshake.
- Single-pass ops: add, sub, or-xor-and, and, xor.
- Multi-cycle op: shift-add multiply.
- Status outputs: carry, signed overflow and illegal-op error, in addition to the existing nonzero flag.
- Sits between the operand/command source and the result consumer in the top-level datapath.

---
 rtl/alu_seq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// WIDTH-bit ALU sequenced by a start/busy/done FSM; single-pass logic/arith ops
// complete in EXEC, multiply runs one shift-add step per cycle in MUL.
module alu_seq_ctrl #(
    parameter int WIDTH = 6,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             carry,
    output logic             ovf,
    output logic             err,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OXA = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    state_t               state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CNTW-1:0]      cnt;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry, alu_ovf, alu_err;
    logic [2*WIDTH-1:0]   addend, acc_next;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        sum_ext   = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_ext   = {1'b0, a_q} + {1'b0, b_q};
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                // Zero-extended subtraction sets the top bit exactly when a < b.
                sum_ext   = {1'b0, a_q} - {1'b0, b_q};
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_OXA:  alu_res = (a_q | b_q) ^ (a_q & b_q);
            OP_AND:  alu_res = a_q & b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        addend   = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;
        acc_next = acc + addend;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flag   <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end else begin
                        result <= alu_res;
                        flag   <= |alu_res;
                        carry  <= alu_carry;
                        ovf    <= alu_ovf;
                        err    <= alu_err;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CNTW'(1);
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        result <= acc_next[WIDTH-1:0];
                        flag   <= |acc_next[WIDTH-1:0];
                        carry  <= 1'b0;
                        ovf    <= |acc_next[2*WIDTH-1:WIDTH];
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
